// File: rtl/mcr_rom_pkg.sv
// ---------------------------------------------------------------------------
// mcr_rom_pkg
//   Shared types for the program-ROM port arbiter.
//   - state_e : arbiter FSM states (IDLE -> ACC -> CAP)
//   - gnt_e   : which requester owns the access currently in flight
//   - SND_BASE_DEF : default base added to the sound CPU address; it maps
//     the 14-bit sound space onto the top 16 KiB of the ROM image
// ---------------------------------------------------------------------------
package mcr_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a pending slot
        ACC  = 2'd1,   // RAM samples mem_addr/mem_we this cycle
        CAP  = 2'd2    // mem_q is valid, capture into the reader register
    } state_e;

    typedef enum logic [1:0] {
        GNT_DL  = 2'd0,
        GNT_CPU = 2'd1,
        GNT_SND = 2'd2
    } gnt_e;

    localparam logic [15:0] SND_BASE_DEF = 16'hC000;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter_if
//   Bundles the download, CPU, sound-CPU and RAM-side signals of the ROM
//   port arbiter.
//   modport slave  : the arbiter (takes requests, drives data/valid and RAM)
//   modport master : the surrounding glue (issues requests, models the RAM)
//   Download : dl_active, dl_wr, dl_addr, dl_data, dl_overrun
//   CPU      : cpu_req, cpu_addr, cpu_data, cpu_valid
//   Sound    : snd_req, snd_addr, snd_data, snd_valid
//   RAM      : mem_addr, mem_we, mem_d, mem_q
// ---------------------------------------------------------------------------
interface rom_port_arbiter_if #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int SND_AW = 14
);
    logic              dl_active;
    logic              dl_wr;
    logic [AW-1:0]     dl_addr;
    logic [DW-1:0]     dl_data;
    logic              dl_overrun;

    logic              cpu_req;
    logic [AW-1:0]     cpu_addr;
    logic [DW-1:0]     cpu_data;
    logic              cpu_valid;

    logic              snd_req;
    logic [SND_AW-1:0] snd_addr;
    logic [DW-1:0]     snd_data;
    logic              snd_valid;

    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_d;
    logic [DW-1:0]     mem_q;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        input  cpu_req, cpu_addr,
        input  snd_req, snd_addr,
        input  mem_q,
        output dl_overrun,
        output cpu_data, cpu_valid,
        output snd_data, snd_valid,
        output mem_addr, mem_we, mem_d
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        output cpu_req, cpu_addr,
        output snd_req, snd_addr,
        output mem_q,
        input  dl_overrun,
        input  cpu_data, cpu_valid,
        input  snd_data, snd_valid,
        input  mem_addr, mem_we, mem_d
    );

endinterface

// File: rtl/rom_req_slot.sv
// ---------------------------------------------------------------------------
// rom_req_slot
//   One request slot of the arbiter: a pending flag plus a payload register
//   loaded on the requester's strobe.
//   clk_sys, reset : clock, synchronous active-high reset
//   strobe         : one-cycle request strobe, payload sampled with it
//   payload        : address (and write data for the download slot)
//   grant          : arbiter takes the slot this cycle; clears pending
//   pending        : slot holds a request not yet granted
//   payload_q      : registered payload
//   overrun        : sticky, a strobe was dropped (DROP_ON_BUSY slots only)
//   With DROP_ON_BUSY=0 a strobe on a pending slot overwrites the payload
//   (readers: newest address wins, one response). With DROP_ON_BUSY=1 the
//   new strobe is discarded and overrun is raised (writer: first write wins).
//   A strobe coinciding with the slot's own grant always starts a new request.
// ---------------------------------------------------------------------------
module rom_req_slot #(
    parameter int PW           = 16,
    parameter bit DROP_ON_BUSY = 1'b0
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          strobe,
    input  logic [PW-1:0] payload,
    input  logic          grant,
    output logic          pending,
    output logic [PW-1:0] payload_q,
    output logic          overrun
);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pending   <= 1'b0;
            payload_q <= '0;
            overrun   <= 1'b0;
        end else if (strobe) begin
            // Busy means still waiting: a slot granted this cycle is free again.
            if (DROP_ON_BUSY && pending && !grant) begin
                overrun <= 1'b1;
            end else begin
                pending   <= 1'b1;
                payload_q <= payload;
            end
        end else if (grant) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter
//   Shares one synchronous single-port program RAM between the ROM download
//   writer, the main CPU fetch and the sound CPU fetch. One access is in
//   flight at a time: IDLE picks a slot and registers the RAM address, ACC
//   lets the RAM sample it, CAP captures mem_q for a read.
//   Ports:
//     clk_sys : system clock
//     reset   : synchronous, active-high
//     bus     : rom_port_arbiter_if.slave (download, CPU, sound, RAM signals)
//   Priority: a pending write always wins; readers are held off while
//   dl_active is high and alternate via a round-robin pointer otherwise.
//   Uncontested read: strobe in cycle c -> valid in cycle c+4.
// ---------------------------------------------------------------------------
module rom_port_arbiter
    import mcr_rom_pkg::*;
#(
    parameter int            AW       = 16,
    parameter int            DW       = 8,
    parameter int            SND_AW   = 14,
    parameter logic [AW-1:0] SND_BASE = AW'(SND_BASE_DEF)
) (
    input  logic              clk_sys,
    input  logic              reset,
    rom_port_arbiter_if.slave bus
);

    // ---------------- request slots ----------------
    logic              dl_pend, cpu_pend, snd_pend;
    logic              grant_dl, grant_cpu, grant_snd;
    logic [AW+DW-1:0]  dl_q;
    logic [AW-1:0]     cpu_q;
    logic [SND_AW-1:0] snd_q;
    logic              dl_ovr;
    logic              cpu_ovr_unused, snd_ovr_unused;

    rom_req_slot #(.PW(AW+DW), .DROP_ON_BUSY(1'b1)) u_dl_slot (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .strobe    (bus.dl_wr),
        .payload   ({bus.dl_addr, bus.dl_data}),
        .grant     (grant_dl),
        .pending   (dl_pend),
        .payload_q (dl_q),
        .overrun   (dl_ovr)
    );

    rom_req_slot #(.PW(AW), .DROP_ON_BUSY(1'b0)) u_cpu_slot (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .strobe    (bus.cpu_req),
        .payload   (bus.cpu_addr),
        .grant     (grant_cpu),
        .pending   (cpu_pend),
        .payload_q (cpu_q),
        .overrun   (cpu_ovr_unused)
    );

    rom_req_slot #(.PW(SND_AW), .DROP_ON_BUSY(1'b0)) u_snd_slot (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .strobe    (bus.snd_req),
        .payload   (bus.snd_addr),
        .grant     (grant_snd),
        .pending   (snd_pend),
        .payload_q (snd_q),
        .overrun   (snd_ovr_unused)
    );

    assign bus.dl_overrun = dl_ovr;

    // Sound space is relocated into the shared image; the sum wraps at AW bits.
    logic [AW-1:0] snd_mem_addr;
    assign snd_mem_addr = SND_BASE + AW'(snd_q);

    // ---------------- arbitration ----------------
    state_e state;
    gnt_e   gnt;
    logic   rr_snd;     // round-robin pointer: 0 = CPU preferred, 1 = sound preferred

    always_comb begin
        grant_dl  = 1'b0;
        grant_cpu = 1'b0;
        grant_snd = 1'b0;
        if (state == IDLE) begin
            if (dl_pend) begin
                grant_dl = 1'b1;
            end else if (!bus.dl_active) begin
                // CPU wins when alone or when the pointer favours it.
                if (cpu_pend && (!snd_pend || !rr_snd))
                    grant_cpu = 1'b1;
                else if (snd_pend)
                    grant_snd = 1'b1;
            end
        end
    end

    // ---------------- access FSM / RAM port ----------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state         <= IDLE;
            gnt           <= GNT_DL;
            rr_snd        <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_d     <= '0;
            bus.cpu_data  <= '0;
            bus.cpu_valid <= 1'b0;
            bus.snd_data  <= '0;
            bus.snd_valid <= 1'b0;
        end else begin
            bus.mem_we    <= 1'b0;
            bus.cpu_valid <= 1'b0;
            bus.snd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // mem_addr/mem_d are left untouched when nothing is granted.
                    if (grant_dl) begin
                        bus.mem_addr <= dl_q[AW+DW-1:DW];
                        bus.mem_d    <= dl_q[DW-1:0];
                        bus.mem_we   <= 1'b1;
                        gnt          <= GNT_DL;
                        state        <= ACC;
                    end else if (grant_cpu) begin
                        bus.mem_addr <= cpu_q;
                        gnt          <= GNT_CPU;
                        state        <= ACC;
                    end else if (grant_snd) begin
                        bus.mem_addr <= snd_mem_addr;
                        gnt          <= GNT_SND;
                        state        <= ACC;
                    end
                end
                ACC: begin
                    state <= (gnt == GNT_DL) ? IDLE : CAP;
                end
                CAP: begin
                    if (gnt == GNT_SND) begin
                        bus.snd_data  <= bus.mem_q;
                        bus.snd_valid <= 1'b1;
                    end else begin
                        bus.cpu_data  <= bus.mem_q;
                        bus.cpu_valid <= 1'b1;
                    end
                    rr_snd <= ~rr_snd;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
